// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI master data path.
// Accepts a parallel TX word through a valid/ready handshake. Driven by the
// leading/trailing edge strobes of an upstream clock divider, it shifts the
// word out on MOSI and samples MISO into an RX word. It also drives chip
// select and publishes each completed RX word with a one-cycle valid pulse.
module spi_shift_engine #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CPHA      = 0,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned CS_HOLD   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_vd,
    output logic              o_tx_rdy,
    input  logic              i_lead_edge,
    input  logic              i_trail_edge,
    input  logic              i_miso,
    output logic              o_mosi,
    output logic              o_cs_n,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_vd
);

    localparam int unsigned CNT_W  = $clog2(2 * DATA_W + 1);
    localparam int unsigned HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

    // Edge count before the final strobe of a word is applied.
    localparam logic [CNT_W-1:0]  LAST_M1   = CNT_W'(2 * DATA_W - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                mosi_q, mosi_d;
    logic                cs_n_q, cs_n_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_vd_q, rx_vd_d;
    logic                exit_now;

    // Bit that goes out next on MOSI.
    function automatic logic tx_head(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    // TX shift register after the head bit has been consumed.
    function automatic logic [DATA_W-1:0] tx_adv(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    // RX shift register after taking in one MISO bit.
    function automatic logic [DATA_W-1:0] rx_adv(input logic [DATA_W-1:0] w, input logic b);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    // State and datapath registers; synchronous reset aborts any transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            edge_cnt_q <= '0;
            hold_cnt_q <= '0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            rx_data_q  <= '0;
            rx_vd_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            edge_cnt_q <= edge_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            rx_data_q  <= rx_data_d;
            rx_vd_q    <= rx_vd_d;
        end
    end

    // Next-state logic: word acceptance, edge-driven shifting, CS hold and exit.
    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        edge_cnt_d = edge_cnt_q;
        hold_cnt_d = hold_cnt_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        rx_data_d  = rx_data_q;
        rx_vd_d    = 1'b0;
        exit_now   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_tx_vd) begin
                    state_d    = ST_XFER;
                    tx_sr_d    = i_tx_data;
                    rx_sr_d    = '0;
                    edge_cnt_d = '0;
                    cs_n_d     = 1'b0;
                    if (CPHA == 0) begin
                        mosi_d  = tx_head(i_tx_data);
                        tx_sr_d = tx_adv(i_tx_data);
                    end
                end
            end

            ST_XFER: begin
                // A coincident lead+trail is handled as a lead alone.
                if (i_lead_edge) begin
                    if (CPHA == 0) begin
                        rx_sr_d = rx_adv(rx_sr_q, i_miso);
                    end else begin
                        mosi_d  = tx_head(tx_sr_q);
                        tx_sr_d = tx_adv(tx_sr_q);
                    end
                end else if (i_trail_edge) begin
                    if (CPHA == 0) begin
                        if (edge_cnt_q != LAST_M1) begin
                            mosi_d  = tx_head(tx_sr_q);
                            tx_sr_d = tx_adv(tx_sr_q);
                        end
                    end else begin
                        rx_sr_d = rx_adv(rx_sr_q, i_miso);
                    end
                end

                if (i_lead_edge || i_trail_edge) begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (edge_cnt_q == LAST_M1) begin
                        // With no hold time the HOLD state is skipped so that
                        // completion lands one cycle after the final strobe.
                        if (CS_HOLD == 0) begin
                            exit_now = 1'b1;
                        end else begin
                            state_d    = ST_HOLD;
                            hold_cnt_d = '0;
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    exit_now = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion publishes the RX word including any shift made this cycle.
        if (exit_now) begin
            state_d   = ST_IDLE;
            rx_data_d = rx_sr_d;
            rx_vd_d   = 1'b1;
            cs_n_d    = 1'b1;
            mosi_d    = 1'b0;
        end
    end

    assign o_tx_rdy  = (state_q == ST_IDLE);
    assign o_busy    = (state_q != ST_IDLE);
    assign o_mosi    = mosi_q;
    assign o_cs_n    = cs_n_q;
    assign o_rx_data = rx_data_q;
    assign o_rx_vd   = rx_vd_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with three parameter variants:
//   u0: CPHA=0 MSB first CS_HOLD=2, MISO looped back from MOSI
//   u1: CPHA=1 MSB first CS_HOLD=0
//   u2: CPHA=1 LSB first CS_HOLD=1
module tb_spi_shift_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst, tx_vd, lead, trail, miso;
    logic [2:0] tx_rdy, mosi, cs_n, busy, rx_vd;
    logic [7:0] tx_data [3];
    logic [7:0] rx_data [3];

    int checks   = 0;
    int failures = 0;
    int vd_cnt [3] = '{0, 0, 0};

    spi_shift_engine #(.DATA_W(8), .CPHA(0), .MSB_FIRST(1), .CS_HOLD(2)) u0 (
        .i_clk(clk), .i_rst(rst[0]), .i_tx_data(tx_data[0]), .i_tx_vd(tx_vd[0]),
        .o_tx_rdy(tx_rdy[0]), .i_lead_edge(lead[0]), .i_trail_edge(trail[0]),
        .i_miso(mosi[0] | miso[0]), .o_mosi(mosi[0]), .o_cs_n(cs_n[0]), .o_busy(busy[0]),
        .o_rx_data(rx_data[0]), .o_rx_vd(rx_vd[0]));

    spi_shift_engine #(.DATA_W(8), .CPHA(1), .MSB_FIRST(1), .CS_HOLD(0)) u1 (
        .i_clk(clk), .i_rst(rst[1]), .i_tx_data(tx_data[1]), .i_tx_vd(tx_vd[1]),
        .o_tx_rdy(tx_rdy[1]), .i_lead_edge(lead[1]), .i_trail_edge(trail[1]),
        .i_miso(miso[1]), .o_mosi(mosi[1]), .o_cs_n(cs_n[1]), .o_busy(busy[1]),
        .o_rx_data(rx_data[1]), .o_rx_vd(rx_vd[1]));

    spi_shift_engine #(.DATA_W(8), .CPHA(1), .MSB_FIRST(0), .CS_HOLD(1)) u2 (
        .i_clk(clk), .i_rst(rst[2]), .i_tx_data(tx_data[2]), .i_tx_vd(tx_vd[2]),
        .o_tx_rdy(tx_rdy[2]), .i_lead_edge(lead[2]), .i_trail_edge(trail[2]),
        .i_miso(miso[2]), .o_mosi(mosi[2]), .o_cs_n(cs_n[2]), .o_busy(busy[2]),
        .o_rx_data(rx_data[2]), .o_rx_vd(rx_vd[2]));

    // Count completion pulses on the falling edge, away from the update edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rx_vd[d] === 1'b1) vd_cnt[d]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int d, input logic [7:0] data);
        tx_data[d] = data;
        tx_vd[d]   = 1'b1;
        tick();
        tx_vd[d]   = 1'b0;
    endtask

    // Sixteen strobe events, one idle cycle between them. seq collects MOSI as
    // the slave would sample it, first bit ending in seq[7]. ok drops if chip
    // select or ready misbehave mid-word, or the engine ends the word early.
    task automatic xfer(input int d, input int cpha, input int coin_at, input int poke_at,
                        output logic [7:0] seq, output bit ok);
        seq = '0;
        ok  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if ((i % 2) == cpha) seq = {seq[6:0], mosi[d]};
            if (busy[d] !== 1'b1) ok = 1'b0;
            lead[d]  = ((i % 2) == 0) || (i == coin_at);
            trail[d] = ((i % 2) == 1);
            if (i == poke_at) begin
                tx_data[d] = 8'h55;
                tx_vd[d]   = 1'b1;
            end
            tick();
            lead[d]  = 1'b0;
            trail[d] = 1'b0;
            tx_vd[d] = 1'b0;
            if (i < 15) begin
                if (cs_n[d] !== 1'b0 || tx_rdy[d] !== 1'b0) ok = 1'b0;
                tick();
                if (cs_n[d] !== 1'b0 || tx_rdy[d] !== 1'b0) ok = 1'b0;
            end
        end
    endtask

    // Called one cycle after the final strobe; lat = cycles until rx_vd seen.
    task automatic wait_vd(input int d, output int lat);
        lat = 1;
        while (rx_vd[d] !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 3'b111;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({tx_rdy[d], cs_n[d], mosi[d], busy[d], rx_vd[d], rx_data[d]} !== 13'b11000_00000000) begin
                failures++;
                $display("FAIL reset_state u%0d got rdy=%b cs_n=%b mosi=%b busy=%b vd=%b rx=%h exp 1 1 0 0 0 00",
                         d, tx_rdy[d], cs_n[d], mosi[d], busy[d], rx_vd[d], rx_data[d]);
            end
        end
        rst = 3'b000;
        tick();
    endtask

    task automatic test_cpha0_loop();
        logic [7:0] seq;
        bit ok;
        int lat, n0;
        start(0, 8'hA5);
        checks++;
        if ({mosi[0], cs_n[0], busy[0], tx_rdy[0]} !== 4'b1010) begin
            failures++;
            $display("FAIL t1_accept got mosi/cs_n/busy/rdy=%b exp 1010",
                     {mosi[0], cs_n[0], busy[0], tx_rdy[0]});
        end
        n0 = vd_cnt[0];
        xfer(0, 0, -1, -1, seq, ok);
        checks++;
        if (seq !== 8'hA5) begin failures++; $display("FAIL t1_mosi_seq got=%h exp=a5", seq); end
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL t1_cs_low got ok=%b exp 1", ok); end
        wait_vd(0, lat);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL t1_latency got=%0d exp=3", lat); end
        checks++;
        if ({rx_data[0], cs_n[0], mosi[0], tx_rdy[0]} !== {8'hA5, 3'b101}) begin
            failures++;
            $display("FAIL t1_done got rx=%h cs_n=%b mosi=%b rdy=%b exp a5 1 0 1",
                     rx_data[0], cs_n[0], mosi[0], tx_rdy[0]);
        end
        tick();
        checks++;
        if (vd_cnt[0] - n0 !== 1 || rx_vd[0] !== 1'b0) begin
            failures++;
            $display("FAIL t1_vd_once got pulses=%0d vd=%b exp 1 0", vd_cnt[0] - n0, rx_vd[0]);
        end
    endtask

    task automatic test_cpha1();
        logic [7:0] seq;
        bit ok;
        int lat;
        miso[1] = 1'b1;
        miso[2] = 1'b1;
        start(1, 8'h3C);
        checks++;
        if ({mosi[1], cs_n[1]} !== 2'b00) begin
            failures++;
            $display("FAIL t2_accept got mosi/cs_n=%b exp 00", {mosi[1], cs_n[1]});
        end
        xfer(1, 1, -1, -1, seq, ok);
        checks++;
        if (seq !== 8'h3C || ok !== 1'b1) begin
            failures++;
            $display("FAIL t2_mosi_seq got=%h ok=%b exp=3c 1", seq, ok);
        end
        wait_vd(1, lat);
        checks++;
        if (lat !== 1 || rx_data[1] !== 8'hFF) begin
            failures++;
            $display("FAIL t2_rx got lat=%0d rx=%h exp 1 ff", lat, rx_data[1]);
        end
        tick();
        start(2, 8'h01);
        xfer(2, 1, -1, -1, seq, ok);
        checks++;
        if (seq !== 8'h80 || ok !== 1'b1) begin
            failures++;
            $display("FAIL t2_lsb_seq got=%h ok=%b exp=80 1", seq, ok);
        end
        wait_vd(2, lat);
        checks++;
        if (lat !== 2 || rx_data[2] !== 8'hFF) begin
            failures++;
            $display("FAIL t2_lsb_rx got lat=%0d rx=%h exp 2 ff", lat, rx_data[2]);
        end
        tick();
    endtask

    task automatic test_ignore_busy();
        logic [7:0] seq;
        bit ok;
        int lat, n0;
        start(0, 8'h0F);
        n0 = vd_cnt[0];
        xfer(0, 0, -1, 4, seq, ok);
        checks++;
        if (seq !== 8'h0F || ok !== 1'b1) begin
            failures++;
            $display("FAIL t3_mosi_seq got=%h ok=%b exp=0f 1", seq, ok);
        end
        wait_vd(0, lat);
        checks++;
        if (lat !== 3 || rx_data[0] !== 8'h0F) begin
            failures++;
            $display("FAIL t3_rx got lat=%0d rx=%h exp 3 0f", lat, rx_data[0]);
        end
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (vd_cnt[0] - n0 !== 1 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL t3_no_queue got pulses=%0d busy=%b exp 1 0", vd_cnt[0] - n0, busy[0]);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] seq;
        bit ok;
        int lat, n0;
        start(0, 8'hC3);
        for (int i = 0; i < 5; i++) begin
            lead[0]  = ((i % 2) == 0);
            trail[0] = ((i % 2) == 1);
            tick();
            lead[0]  = 1'b0;
            trail[0] = 1'b0;
            tick();
        end
        n0 = vd_cnt[0];
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        checks++;
        if ({cs_n[0], busy[0], tx_rdy[0], mosi[0], rx_data[0]} !== {4'b1010, 8'h00}) begin
            failures++;
            $display("FAIL t4_abort got cs_n=%b busy=%b rdy=%b mosi=%b rx=%h exp 1 0 1 0 00",
                     cs_n[0], busy[0], tx_rdy[0], mosi[0], rx_data[0]);
        end
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (vd_cnt[0] !== n0) begin
            failures++;
            $display("FAIL t4_no_vd got pulses=%0d exp 0", vd_cnt[0] - n0);
        end
        start(0, 8'h81);
        xfer(0, 0, -1, -1, seq, ok);
        wait_vd(0, lat);
        checks++;
        if (seq !== 8'h81 || ok !== 1'b1 || lat !== 3 || rx_data[0] !== 8'h81) begin
            failures++;
            $display("FAIL t4_after got seq=%h ok=%b lat=%0d rx=%h exp 81 1 3 81", seq, ok, lat, rx_data[0]);
        end
        tick();
    endtask

    task automatic test_strobes();
        logic [7:0] seq;
        bit ok, idle_ok;
        int lat, n0;
        n0 = vd_cnt[1];
        idle_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lead[1]  = (i != 1);
            trail[1] = (i != 0);
            tick();
            lead[1]  = 1'b0;
            trail[1] = 1'b0;
            if ({busy[1], cs_n[1], tx_rdy[1], mosi[1], rx_vd[1]} !== 5'b01100) idle_ok = 1'b0;
        end
        tick();
        checks++;
        if (idle_ok !== 1'b1 || vd_cnt[1] !== n0) begin
            failures++;
            $display("FAIL t5_idle_strobes got ok=%b pulses=%0d exp 1 0", idle_ok, vd_cnt[1] - n0);
        end
        miso[1] = 1'b1;
        start(1, 8'h3C);
        xfer(1, 1, 5, -1, seq, ok);
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL t5_coincide_busy got ok=%b exp 1", ok); end
        wait_vd(1, lat);
        checks++;
        if (lat !== 1 || rx_data[1] !== 8'h7F) begin
            failures++;
            $display("FAIL t5_coincide_rx got lat=%0d rx=%h exp 1 7f", lat, rx_data[1]);
        end
        tick();
        checks++;
        if (busy[1] !== 1'b0 || mosi[1] === 1'bx) begin
            failures++;
            $display("FAIL t5_idle_after got busy=%b mosi=%b exp 0 0", busy[1], mosi[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq;
        bit ok;
        int lat;
        start(0, 8'h12);
        xfer(0, 0, -1, -1, seq, ok);
        tx_data[0] = 8'h34;
        tx_vd[0]   = 1'b1;
        wait_vd(0, lat);
        checks++;
        if (seq !== 8'h12 || lat !== 3 || rx_data[0] !== 8'h12) begin
            failures++;
            $display("FAIL t6_first got seq=%h lat=%0d rx=%h exp 12 3 12", seq, lat, rx_data[0]);
        end
        checks++;
        if ({cs_n[0], tx_rdy[0]} !== 2'b11) begin
            failures++;
            $display("FAIL t6_gap got cs_n/rdy=%b exp 11", {cs_n[0], tx_rdy[0]});
        end
        tick();
        tx_vd[0] = 1'b0;
        checks++;
        if ({cs_n[0], busy[0], mosi[0]} !== 3'b010) begin
            failures++;
            $display("FAIL t6_restart got cs_n/busy/mosi=%b exp 010", {cs_n[0], busy[0], mosi[0]});
        end
        xfer(0, 0, -1, -1, seq, ok);
        wait_vd(0, lat);
        checks++;
        if (seq !== 8'h34 || ok !== 1'b1 || lat !== 3 || rx_data[0] !== 8'h34) begin
            failures++;
            $display("FAIL t6_second got seq=%h ok=%b lat=%0d rx=%h exp 34 1 3 34", seq, ok, lat, rx_data[0]);
        end
        tick();
    endtask

    initial begin
        rst   = 3'b111;
        tx_vd = 3'b000;
        lead  = 3'b000;
        trail = 3'b000;
        miso  = 3'b000;
        for (int d = 0; d < 3; d++) tx_data[d] = 8'h00;
        test_reset();
        test_cpha0_loop();
        test_cpha1();
        test_ignore_busy();
        test_reset_abort();
        test_strobes();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
